// File: rtl/reg_arbiter.sv
// -----------------------------------------------------------------------------
// reg_arbiter
//
// Two-requester round-robin arbiter placed in front of the shared 2-bit
// registered datapath. It grants the datapath to one requester at a time for
// at most HOLD consecutive cycles and steers that requester's operands onto
// the datapath a/b inputs.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (dominates all requests)
//   req0, req1   requester 0 / 1 wants the datapath
//   a0, b0       requester 0 operands
//   a1, b1       requester 1 operands
//   gnt[1:0]     one-hot registered grant (bit0 = requester 0, bit1 = req 1)
//   a_out, b_out steered operands for the datapath a/b inputs
//   busy         high whenever gnt is non-zero
//
// Handshake: a requester holds reqN high for as long as it wants the
// datapath. gntN (registered) says its operands are on a_out/b_out in that
// cycle; the datapath samples them on the following posedge. Dropping reqN
// releases the grant on the next edge.
//
// The FSM state is encoded so that it *is* the grant vector; gnt exposes the
// state directly.
// -----------------------------------------------------------------------------
module reg_arbiter #(
  parameter int unsigned HOLD = 2  // max consecutive grant cycles, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       a0,
  input  logic       b0,
  input  logic       a1,
  input  logic       b1,
  output logic [1:0] gnt,
  output logic       a_out,
  output logic       b_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic [3:0] RELOAD = 4'(HOLD - 1);

  state_t     state, state_next;
  logic [3:0] hold_cnt, hold_cnt_next;
  logic       last, last_next;   // id of the most recent grantee
  logic       cnt_zero;

  assign cnt_zero = (hold_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      last     <= 1'b1;          // requester 0 wins the first tie
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      last     <= last_next;
    end
  end

  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    last_next     = last;

    case (state)
      IDLE: begin
        if (req0 && req1) begin
          // Tie: grant whoever did not have it most recently.
          state_next = last ? G0 : G1;
          last_next  = ~last;
          hold_cnt_next = RELOAD;
        end else if (req0) begin
          state_next    = G0;
          last_next     = 1'b0;
          hold_cnt_next = RELOAD;
        end else if (req1) begin
          state_next    = G1;
          last_next     = 1'b1;
          hold_cnt_next = RELOAD;
        end
      end

      G0: begin
        hold_cnt_next = cnt_zero ? 4'd0 : hold_cnt - 4'd1;
        // Tenure ends when the owner lets go or its budget is used up.
        if (!req0 || cnt_zero) begin
          if (req1) begin
            state_next    = G1;
            last_next     = 1'b1;
            hold_cnt_next = RELOAD;
          end else if (req0) begin
            state_next    = G0;
            last_next     = 1'b0;
            hold_cnt_next = RELOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end

      G1: begin
        hold_cnt_next = cnt_zero ? 4'd0 : hold_cnt - 4'd1;
        if (!req1 || cnt_zero) begin
          if (req0) begin
            state_next    = G0;
            last_next     = 1'b0;
            hold_cnt_next = RELOAD;
          end else if (req1) begin
            state_next    = G1;
            last_next     = 1'b1;
            hold_cnt_next = RELOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt  = state;
  assign busy = |state;

  // Operand steering follows the registered grant, so operands appear in the
  // same cycle the grant does.
  always_comb begin
    a_out = 1'b0;
    b_out = 1'b0;
    case (state)
      G0: begin
        a_out = a0;
        b_out = b0;
      end
      G1: begin
        a_out = a1;
        b_out = b1;
      end
      default: begin
        a_out = 1'b0;
        b_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_arbiter
//
// Directed bench for reg_arbiter. Two instances share clk/rst: dut uses the
// default HOLD=2, dut_h1 uses HOLD=1. Outputs are sampled 1 time unit after
// each rising edge; inputs are changed at that same point so they are stable
// well before the next edge.
// -----------------------------------------------------------------------------
module tb_reg_arbiter;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // HOLD=2 instance signals
  logic       req0, req1, a0, b0, a1, b1;
  logic [1:0] gnt;
  logic       a_out, b_out, busy;

  // HOLD=1 instance signals
  logic       req0_h, req1_h, a0_h, b0_h, a1_h, b1_h;
  logic [1:0] gnt_h;
  logic       a_out_h, b_out_h, busy_h;

  int n_checks = 0;
  int n_fail   = 0;

  reg_arbiter #(.HOLD(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .gnt   (gnt),
    .a_out (a_out),
    .b_out (b_out),
    .busy  (busy)
  );

  reg_arbiter #(.HOLD(1)) dut_h1 (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0_h),
    .req1  (req1_h),
    .a0    (a0_h),
    .b0    (b0_h),
    .a1    (a1_h),
    .b1    (b1_h),
    .gnt   (gnt_h),
    .a_out (a_out_h),
    .b_out (b_out_h),
    .busy  (busy_h)
  );

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic exp_main(input string tag, input logic [1:0] g, input logic ea, input logic eb);
    chk({tag, ".gnt"},  gnt, g);
    chk({tag, ".busy"}, {1'b0, busy},  {1'b0, |g});
    chk({tag, ".a"},    {1'b0, a_out}, {1'b0, ea});
    chk({tag, ".b"},    {1'b0, b_out}, {1'b0, eb});
  endtask

  task automatic exp_h1(input string tag, input logic [1:0] g, input logic ea, input logic eb);
    chk({tag, ".gnt"},  gnt_h, g);
    chk({tag, ".busy"}, {1'b0, busy_h},  {1'b0, |g});
    chk({tag, ".a"},    {1'b0, a_out_h}, {1'b0, ea});
    chk({tag, ".b"},    {1'b0, b_out_h}, {1'b0, eb});
  endtask

  initial begin
    rst  = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 1'b1; b0 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    req0_h = 1'b0; req1_h = 1'b0;
    a0_h = 1'b1; b0_h = 1'b0; a1_h = 1'b0; b1_h = 1'b1;

    // Reset dominates requests for two edges
    step(); exp_main("rst_e1", 2'b00, 1'b0, 1'b0);
            exp_h1  ("rst_e1_h1", 2'b00, 1'b0, 1'b0);
    step(); exp_main("rst_e2", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;

    // Contention with HOLD=2: 01,01,10,10,01,01
    step(); exp_main("cont_1", 2'b01, 1'b1, 1'b0);
    step(); exp_main("cont_2", 2'b01, 1'b1, 1'b0);
    step(); exp_main("cont_3", 2'b10, 1'b0, 1'b1);
    step(); exp_main("cont_4", 2'b10, 1'b0, 1'b1);
    step(); exp_main("cont_5", 2'b01, 1'b1, 1'b0);
    step(); exp_main("cont_6", 2'b01, 1'b1, 1'b0);
    step(); exp_main("cont_7", 2'b10, 1'b0, 1'b1);
    exp_h1("idle_h1", 2'b00, 1'b0, 1'b0);

    // Reset pulse in the middle of a G1 tenure, then tie goes to requester 0
    rst = 1'b1;
    step(); exp_main("rst_mid", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    step(); exp_main("rst_tie", 2'b01, 1'b1, 1'b0);

    // Early release: owner drops after one cycle, other side takes over
    req0 = 1'b0;
    step(); exp_main("early_rel", 2'b10, 1'b0, 1'b1);

    // Single requester 0: switch in, then continuous re-grants with no gap
    req1 = 1'b0; req0 = 1'b1;
    step(); exp_main("single_sw", 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); exp_main($sformatf("single_hold%0d", i), 2'b01, 1'b1, 1'b0);
    end

    // Operand changes reach a_out/b_out combinationally while granted
    a0 = 1'b0; b0 = 1'b1;
    #1; exp_main("comb_steer", 2'b01, 1'b0, 1'b1);

    // Request drop: back to IDLE, operands no longer steered
    a0 = 1'b1; b0 = 1'b0; req0 = 1'b0;
    step(); exp_main("drop_idle", 2'b00, 1'b0, 1'b0);

    // Lone requester 1 from IDLE: one edge of latency
    req1 = 1'b1;
    step(); exp_main("req1_only", 2'b10, 1'b0, 1'b1);

    // HOLD=1 alternation with both requests held high
    req0_h = 1'b1; req1_h = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i % 2 == 0) exp_h1($sformatf("alt%0d", i), 2'b01, 1'b1, 1'b0);
      else            exp_h1($sformatf("alt%0d", i), 2'b10, 1'b0, 1'b1);
    end

    // HOLD=1 lone requester 0: single-cycle re-grants look continuous
    req1_h = 1'b0;
    step(); exp_h1("h1_single_a", 2'b01, 1'b1, 1'b0);
    step(); exp_h1("h1_single_b", 2'b01, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
